// File: rtl/tl_rx_cpl_tag_tracker.sv
// Completion tag tracker for the receive transaction layer.
// Hands out free tags to outgoing requests, matches incoming completions
// against outstanding tags, flags unexpected completions and retires
// tags whose completion timer has run out (one timeout report per cycle).
module tl_rx_cpl_tag_tracker #(
    parameter int TAG_WIDTH          = 5,
    parameter int REQUESTER_ID_WIDTH = 16,
    parameter int TIMER_WIDTH        = 16,
    parameter int TIMEOUT            = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uc_en,
    input  logic [REQUESTER_ID_WIDTH-1:0] own_req_id,
    input  logic                          alloc_req,
    output logic                          alloc_gnt,
    output logic [TAG_WIDTH-1:0]          alloc_tag,
    input  logic                          cpl_valid,
    input  logic [TAG_WIDTH-1:0]          cpl_tag,
    input  logic [REQUESTER_ID_WIDTH-1:0] cpl_req_id,
    input  logic                          cpl_last,
    output logic                          uc_error,
    output logic [TAG_WIDTH-1:0]          uc_tag,
    output logic                          cpl_timeout,
    output logic [TAG_WIDTH-1:0]          timeout_tag,
    output logic [TAG_WIDTH:0]            outstanding_cnt,
    output logic                          full,
    output logic                          empty
);

    localparam int NUM_TAGS = 2 ** TAG_WIDTH;
    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_VAL = TIMER_WIDTH'(TIMEOUT);

    logic [NUM_TAGS-1:0]    busy;
    logic [NUM_TAGS-1:0]    seen;
    logic [TIMER_WIDTH-1:0] timer [NUM_TAGS];

    logic [NUM_TAGS-1:0]    busy_next;
    logic [NUM_TAGS-1:0]    seen_next;
    logic [TIMER_WIDTH-1:0] timer_next [NUM_TAGS];

    logic                   free_found;
    logic [TAG_WIDTH-1:0]   free_tag;
    logic                   cpl_hit;
    logic                   cpl_retire;
    logic                   to_fire;
    logic [TAG_WIDTH-1:0]   to_tag;

    // Lowest-index free entry drives the grant.
    always_comb begin
        free_found = 1'b0;
        free_tag   = '0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if (!busy[i] && !free_found) begin
                free_found = 1'b1;
                free_tag   = TAG_WIDTH'(i);
            end
        end
        alloc_gnt = alloc_req && free_found;
        alloc_tag = free_tag;
    end

    // Completion match and lowest-index expired entry; a completion to an
    // expiring entry masks it out so the completion wins.
    always_comb begin
        cpl_hit    = cpl_valid && busy[cpl_tag] && (cpl_req_id == own_req_id);
        cpl_retire = cpl_hit && cpl_last;
        to_fire    = 1'b0;
        to_tag     = '0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if (busy[i] && (timer[i] == TIMEOUT_VAL) && !to_fire &&
                !(cpl_hit && (cpl_tag == TAG_WIDTH'(i)))) begin
                to_fire = 1'b1;
                to_tag  = TAG_WIDTH'(i);
            end
        end
    end

    // Per-entry next state: grant, completion and timeout touch disjoint
    // entries (a grant only targets a free entry), so priority order is moot.
    always_comb begin
        busy_next = busy;
        seen_next = seen;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            timer_next[i] = timer[i];
            if (busy[i] && (timer[i] != TIMEOUT_VAL)) begin
                timer_next[i] = timer[i] + TIMER_WIDTH'(1);
            end
            if (alloc_gnt && (free_tag == TAG_WIDTH'(i))) begin
                busy_next[i]  = 1'b1;
                seen_next[i]  = 1'b0;
                timer_next[i] = '0;
            end else if (cpl_hit && (cpl_tag == TAG_WIDTH'(i))) begin
                timer_next[i] = '0;
                if (cpl_last) begin
                    busy_next[i] = 1'b0;
                    seen_next[i] = 1'b0;
                end else begin
                    seen_next[i] = 1'b1;
                end
            end else if (to_fire && (to_tag == TAG_WIDTH'(i))) begin
                busy_next[i]  = 1'b0;
                seen_next[i]  = 1'b0;
                timer_next[i] = '0;
            end
        end
    end

    // Entry state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
            seen <= '0;
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                timer[i] <= '0;
            end
        end else begin
            busy <= busy_next;
            seen <= seen_next;
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                timer[i] <= timer_next[i];
            end
        end
    end

    // Registered error/timeout pulses and the outstanding counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uc_error        <= 1'b0;
            uc_tag          <= '0;
            cpl_timeout     <= 1'b0;
            timeout_tag     <= '0;
            outstanding_cnt <= '0;
        end else begin
            uc_error    <= cpl_valid && !cpl_hit && uc_en;
            if (cpl_valid && !cpl_hit && uc_en) begin
                uc_tag <= cpl_tag;
            end
            cpl_timeout <= to_fire;
            if (to_fire) begin
                timeout_tag <= to_tag;
            end
            outstanding_cnt <= outstanding_cnt
                             + (TAG_WIDTH+1)'(alloc_gnt)
                             - (TAG_WIDTH+1)'(cpl_retire)
                             - (TAG_WIDTH+1)'(to_fire);
        end
    end

    assign full  = (outstanding_cnt == (TAG_WIDTH+1)'(NUM_TAGS));
    assign empty = (outstanding_cnt == '0);

endmodule

// File: tb/tb_tl_rx_cpl_tag_tracker.sv
// Directed testbench for tl_rx_cpl_tag_tracker: one default instance and
// one with TIMEOUT=4 for the timeout scenarios.
module tb_tl_rx_cpl_tag_tracker;

    localparam logic [15:0] OWN_ID = 16'h0100;
    localparam logic [15:0] BAD_ID = 16'h0200;

    logic        clk = 1'b0;
    logic        rst;
    logic        uc_en;
    logic [15:0] own_req_id;

    logic        alloc_req, alloc_gnt, cpl_valid, cpl_last;
    logic [4:0]  alloc_tag, cpl_tag, uc_tag, timeout_tag;
    logic [15:0] cpl_req_id;
    logic        uc_error, cpl_timeout, full, empty;
    logic [5:0]  outstanding_cnt;

    logic        t_alloc_req, t_alloc_gnt, t_cpl_valid, t_cpl_last;
    logic [4:0]  t_alloc_tag, t_cpl_tag, t_uc_tag, t_timeout_tag;
    logic [15:0] t_cpl_req_id;
    logic        t_uc_error, t_cpl_timeout, t_full, t_empty;
    logic [5:0]  t_outstanding_cnt;

    int checks = 0;
    int errors = 0;

    tl_rx_cpl_tag_tracker dut (
        .clk(clk), .rst(rst), .uc_en(uc_en), .own_req_id(own_req_id),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
        .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_req_id(cpl_req_id),
        .cpl_last(cpl_last), .uc_error(uc_error), .uc_tag(uc_tag),
        .cpl_timeout(cpl_timeout), .timeout_tag(timeout_tag),
        .outstanding_cnt(outstanding_cnt), .full(full), .empty(empty)
    );

    tl_rx_cpl_tag_tracker #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst), .uc_en(uc_en), .own_req_id(own_req_id),
        .alloc_req(t_alloc_req), .alloc_gnt(t_alloc_gnt), .alloc_tag(t_alloc_tag),
        .cpl_valid(t_cpl_valid), .cpl_tag(t_cpl_tag), .cpl_req_id(t_cpl_req_id),
        .cpl_last(t_cpl_last), .uc_error(t_uc_error), .uc_tag(t_uc_tag),
        .cpl_timeout(t_cpl_timeout), .timeout_tag(t_timeout_tag),
        .outstanding_cnt(t_outstanding_cnt), .full(t_full), .empty(t_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        checks++; if (outstanding_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", outstanding_cnt); end
        checks++; if ({empty, full} !== 2'b10) begin errors++; $display("FAIL reset_empty_full: got %b expected 10", {empty, full}); end
        checks++; if ({uc_error, cpl_timeout} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {uc_error, cpl_timeout}); end
        checks++; if ({uc_tag, timeout_tag} !== 10'd0) begin errors++; $display("FAIL reset_tags: got %0d/%0d expected 0/0", uc_tag, timeout_tag); end
        checks++; if ({alloc_gnt, alloc_tag} !== 6'd0) begin errors++; $display("FAIL reset_alloc: got gnt %b tag %0d expected 0/0", alloc_gnt, alloc_tag); end
        checks++; if (t_outstanding_cnt !== 6'd0) begin errors++; $display("FAIL reset_t_cnt: got %0d expected 0", t_outstanding_cnt); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_alloc();
        for (int i = 0; i < 3; i++) begin
            alloc_req = 1'b1;
            #1;
            checks++; if ({alloc_gnt, alloc_tag} !== {1'b1, 5'(i)}) begin errors++; $display("FAIL alloc_seq: got gnt %b tag %0d expected 1/%0d", alloc_gnt, alloc_tag, i); end
            tick();
        end
        alloc_req = 1'b0;
        checks++; if (outstanding_cnt !== 6'd3) begin errors++; $display("FAIL alloc_cnt: got %0d expected 3", outstanding_cnt); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL alloc_empty: got %b expected 0", empty); end
    endtask

    task automatic test_cpl_retire();
        cpl_valid = 1'b1; cpl_tag = 5'd1; cpl_req_id = OWN_ID; cpl_last = 1'b1;
        tick();
        cpl_valid = 1'b0;
        checks++; if (uc_error !== 1'b0) begin errors++; $display("FAIL retire_uc: got %b expected 0", uc_error); end
        checks++; if (outstanding_cnt !== 6'd2) begin errors++; $display("FAIL retire_cnt: got %0d expected 2", outstanding_cnt); end
        alloc_req = 1'b1;
        #1;
        checks++; if ({alloc_gnt, alloc_tag} !== {1'b1, 5'd1}) begin errors++; $display("FAIL retire_regrant: got gnt %b tag %0d expected 1/1", alloc_gnt, alloc_tag); end
        tick();
        alloc_req = 1'b0;
        checks++; if (outstanding_cnt !== 6'd3) begin errors++; $display("FAIL retire_cnt2: got %0d expected 3", outstanding_cnt); end
    endtask

    task automatic test_unexpected();
        uc_en = 1'b1;
        cpl_valid = 1'b1; cpl_tag = 5'd7; cpl_req_id = OWN_ID; cpl_last = 1'b1;
        tick();
        checks++; if ({uc_error, uc_tag} !== {1'b1, 5'd7}) begin errors++; $display("FAIL uc_free_tag: got %b/%0d expected 1/7", uc_error, uc_tag); end
        cpl_tag = 5'd0; cpl_req_id = BAD_ID;
        tick();
        checks++; if ({uc_error, uc_tag} !== {1'b1, 5'd0}) begin errors++; $display("FAIL uc_bad_id: got %b/%0d expected 1/0", uc_error, uc_tag); end
        cpl_valid = 1'b0;
        tick();
        checks++; if (uc_error !== 1'b0) begin errors++; $display("FAIL uc_one_cycle: got %b expected 0", uc_error); end
        checks++; if (outstanding_cnt !== 6'd3) begin errors++; $display("FAIL uc_cnt: got %0d expected 3", outstanding_cnt); end
        checks++; if (alloc_tag !== 5'd3) begin errors++; $display("FAIL uc_tag0_busy: got %0d expected 3", alloc_tag); end
        uc_en = 1'b0;
        cpl_valid = 1'b1; cpl_tag = 5'd9; cpl_req_id = OWN_ID;
        tick();
        cpl_valid = 1'b0;
        checks++; if (uc_error !== 1'b0) begin errors++; $display("FAIL uc_disabled: got %b expected 0", uc_error); end
        uc_en = 1'b1;
        cpl_valid = 1'b1; cpl_tag = 5'd2; cpl_last = 1'b0;
        tick();
        checks++; if ({uc_error, outstanding_cnt} !== {1'b0, 6'd3}) begin errors++; $display("FAIL cpl_partial: got uc %b cnt %0d expected 0/3", uc_error, outstanding_cnt); end
        cpl_last = 1'b1;
        tick();
        cpl_valid = 1'b0;
        checks++; if ({uc_error, outstanding_cnt} !== {1'b0, 6'd2}) begin errors++; $display("FAIL cpl_final: got uc %b cnt %0d expected 0/2", uc_error, outstanding_cnt); end
    endtask

    task automatic test_reset_mid();
        reset_pulse();
        alloc_req = 1'b1;
        repeat (10) tick();
        alloc_req = 1'b0;
        checks++; if (outstanding_cnt !== 6'd10) begin errors++; $display("FAIL mid_cnt10: got %0d expected 10", outstanding_cnt); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({outstanding_cnt, empty} !== {6'd0, 1'b1}) begin errors++; $display("FAIL mid_async: got cnt %0d empty %b expected 0/1", outstanding_cnt, empty); end
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if ({uc_error, cpl_timeout} !== 2'b00) begin errors++; $display("FAIL mid_no_pulse: got %b expected 00", {uc_error, cpl_timeout}); end
        end
        checks++; if (alloc_tag !== 5'd0) begin errors++; $display("FAIL mid_free: got %0d expected 0", alloc_tag); end
    endtask

    task automatic test_full();
        reset_pulse();
        for (int i = 0; i < 32; i++) begin
            alloc_req = 1'b1;
            #1;
            checks++; if ({alloc_gnt, alloc_tag} !== {1'b1, 5'(i)}) begin errors++; $display("FAIL full_seq: got gnt %b tag %0d expected 1/%0d", alloc_gnt, alloc_tag, i); end
            tick();
        end
        checks++; if ({full, outstanding_cnt} !== {1'b1, 6'd32}) begin errors++; $display("FAIL full_flag: got full %b cnt %0d expected 1/32", full, outstanding_cnt); end
        cpl_valid = 1'b1; cpl_tag = 5'd5; cpl_req_id = OWN_ID; cpl_last = 1'b1;
        #1;
        checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL full_no_gnt: got %b expected 0", alloc_gnt); end
        tick();
        cpl_valid = 1'b0;
        #1;
        checks++; if ({alloc_gnt, alloc_tag} !== {1'b1, 5'd5}) begin errors++; $display("FAIL full_regrant: got gnt %b tag %0d expected 1/5", alloc_gnt, alloc_tag); end
        checks++; if ({full, outstanding_cnt} !== {1'b0, 6'd31}) begin errors++; $display("FAIL full_drop: got full %b cnt %0d expected 0/31", full, outstanding_cnt); end
        tick();
        alloc_req = 1'b0;
        checks++; if ({full, outstanding_cnt} !== {1'b1, 6'd32}) begin errors++; $display("FAIL full_refill: got full %b cnt %0d expected 1/32", full, outstanding_cnt); end
    endtask

    task automatic test_timeout();
        reset_pulse();
        t_alloc_req = 1'b1;
        tick();
        t_cpl_valid = 1'b1; t_cpl_tag = 5'd0; t_cpl_req_id = OWN_ID; t_cpl_last = 1'b0;
        tick();
        t_alloc_req = 1'b0; t_cpl_valid = 1'b0;
        checks++; if (t_outstanding_cnt !== 6'd2) begin errors++; $display("FAIL to_cnt2: got %0d expected 2", t_outstanding_cnt); end
        for (int k = 2; k <= 5; k++) begin
            tick();
            checks++; if (t_cpl_timeout !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0 at cycle %0d", t_cpl_timeout, k); end
        end
        tick();
        checks++; if ({t_cpl_timeout, t_timeout_tag, t_outstanding_cnt} !== {1'b1, 5'd0, 6'd1}) begin errors++; $display("FAIL to_tag0: got %b/%0d cnt %0d expected 1/0 cnt 1", t_cpl_timeout, t_timeout_tag, t_outstanding_cnt); end
        tick();
        checks++; if ({t_cpl_timeout, t_timeout_tag, t_outstanding_cnt} !== {1'b1, 5'd1, 6'd0}) begin errors++; $display("FAIL to_tag1: got %b/%0d cnt %0d expected 1/1 cnt 0", t_cpl_timeout, t_timeout_tag, t_outstanding_cnt); end
        checks++; if (t_empty !== 1'b1) begin errors++; $display("FAIL to_empty: got %b expected 1", t_empty); end
        tick();
        checks++; if (t_cpl_timeout !== 1'b0) begin errors++; $display("FAIL to_end: got %b expected 0", t_cpl_timeout); end
        uc_en = 1'b1;
        t_cpl_valid = 1'b1; t_cpl_tag = 5'd0; t_cpl_last = 1'b1;
        tick();
        t_cpl_valid = 1'b0;
        checks++; if ({t_uc_error, t_uc_tag} !== {1'b1, 5'd0}) begin errors++; $display("FAIL to_late_cpl: got %b/%0d expected 1/0", t_uc_error, t_uc_tag); end
    endtask

    task automatic test_cpl_on_expiry();
        t_alloc_req = 1'b1;
        tick();
        t_alloc_req = 1'b0;
        repeat (4) tick();
        t_cpl_valid = 1'b1; t_cpl_tag = 5'd0; t_cpl_req_id = OWN_ID; t_cpl_last = 1'b1;
        tick();
        t_cpl_valid = 1'b0;
        checks++; if ({t_cpl_timeout, t_uc_error} !== 2'b00) begin errors++; $display("FAIL exp_race: got %b expected 00", {t_cpl_timeout, t_uc_error}); end
        checks++; if (t_outstanding_cnt !== 6'd0) begin errors++; $display("FAIL exp_cnt: got %0d expected 0", t_outstanding_cnt); end
        tick();
        checks++; if (t_cpl_timeout !== 1'b0) begin errors++; $display("FAIL exp_after: got %b expected 0", t_cpl_timeout); end
    endtask

    initial begin
        rst = 1'b0; uc_en = 1'b0; own_req_id = OWN_ID;
        alloc_req = 1'b0; cpl_valid = 1'b0; cpl_tag = '0; cpl_req_id = '0; cpl_last = 1'b0;
        t_alloc_req = 1'b0; t_cpl_valid = 1'b0; t_cpl_tag = '0; t_cpl_req_id = '0; t_cpl_last = 1'b0;
        test_reset();
        test_alloc();
        test_cpl_retire();
        test_unexpected();
        test_reset_mid();
        test_full();
        test_timeout();
        test_cpl_on_expiry();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/tl_rx_cpl_tag_tracker.md
TL_RX_CPL_TAG_TRACKER -- requirements
Module: tl_rx_cpl_tag_tracker

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 5, giving the tag field width; NUM_TAGS = 2**TAG_WIDTH tracked entries.
REQ-002 SHALL have parameter REQUESTER_ID_WIDTH, default 16, giving the requester ID width.
REQ-003 SHALL have parameter TIMER_WIDTH, default 16, giving the per-entry timer width.
REQ-004 SHALL have parameter TIMEOUT, default 1000, giving the completion timeout in clk cycles; 1 <= TIMEOUT < 2**TIMER_WIDTH.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 uc_en  input  1  unexpected-completion error reporting enable.
REQ-008 own_req_id  input  REQUESTER_ID_WIDTH  this function's requester ID.
REQ-009 alloc_req  input  1  TX request needs a tag.
REQ-010 alloc_gnt  output  1  tag granted this cycle (combinational).
REQ-011 alloc_tag  output  TAG_WIDTH  granted tag (combinational).
REQ-012 cpl_valid  input  1  RX completion header valid, one cycle per completion.
REQ-013 cpl_tag  input  TAG_WIDTH  completion tag.
REQ-014 cpl_req_id  input  REQUESTER_ID_WIDTH  completion requester ID.
REQ-015 cpl_last  input  1  final completion for the request.
REQ-016 uc_error / uc_tag  output  1 / TAG_WIDTH  registered unexpected-completion pulse and offending tag.
REQ-017 cpl_timeout / timeout_tag  output  1 / TAG_WIDTH  registered timeout pulse and expired tag.
REQ-018 outstanding_cnt  output  TAG_WIDTH+1  busy entry count (registered).
REQ-019 full / empty  output  1 / 1  outstanding_cnt == NUM_TAGS / == 0.

Function
REQ-020 SHALL hold per entry a busy bit, a completion-seen bit and a TIMER_WIDTH timer.
REQ-021 alloc_gnt SHALL be alloc_req AND at least one free entry; alloc_tag SHALL be the lowest-index free entry, and 0 when none is free.
REQ-022 On a grant, the entry SHALL become busy at the next edge with its timer cleared; full SHALL deassert alloc_gnt.
REQ-023 A completion SHALL be expected when cpl_valid, the cpl_tag entry is busy, and cpl_req_id == own_req_id.
REQ-024 An expected completion with cpl_last=1 SHALL free the entry at the next edge.
REQ-025 An expected completion with cpl_last=0 SHALL keep the entry busy and clear its timer.
REQ-026 An unexpected completion SHALL leave all entries unchanged.
REQ-027 An unexpected completion with uc_en=1 SHALL assert uc_error for exactly one cycle, on the next edge, with uc_tag = cpl_tag; with uc_en=0 it SHALL be silently dropped.
REQ-028 The timer of every busy entry SHALL increment each cycle and saturate at TIMEOUT.
REQ-029 A busy entry whose timer equals TIMEOUT SHALL be expired.
REQ-030 Per cycle, the lowest-index expired entry SHALL be freed; the next edge SHALL pulse cpl_timeout with timeout_tag = that index.
REQ-031 Other expired entries SHALL remain pending and be reported one per cycle afterwards in ascending index order.
REQ-032 If a completion targets an entry in the same cycle that entry is expired or selected for timeout, the completion SHALL win: it is handled per REQ-024/025 and no timeout is reported for that entry.
REQ-033 A later completion to a timed-out tag SHALL be unexpected.
REQ-034 Allocation and retirement in the same cycle SHALL both take effect; outstanding_cnt SHALL change by (+grant - completion retire - timeout retire).
REQ-035 A freed entry SHALL be grantable from the cycle after it is freed.
REQ-036 uc_en SHALL not affect allocation, retirement or timeout.

Reset
REQ-037 While rst=0, all entries SHALL be free with timers 0, uc_error=0, uc_tag=0, cpl_timeout=0, timeout_tag=0, outstanding_cnt=0, empty=1 and full=0.
REQ-038 Reset asserted mid-operation SHALL discard all outstanding tags without reporting a timeout or error.

Verification
REQ-039 SHALL cover: reset, then alloc_req for 3 cycles -> tags 0,1,2 granted; outstanding_cnt=3.
REQ-040 SHALL cover: cpl_valid with tag 1, matching ID, cpl_last=1 -> no uc_error; tag 1 is the next grant; outstanding_cnt=2.
REQ-041 SHALL cover: uc_en=1, cpl to free tag 7, then cpl to tag 0 with a wrong ID -> two uc_error pulses (uc_tag 7, 0); tag 0 stays busy.
REQ-042 SHALL cover: TIMEOUT=4, tags 0 and 1 allocated in the same cycle window, no completions -> cpl_timeout for tag 0, then tag 1 the next cycle; empty=1 afterwards.
REQ-043 SHALL cover: all 32 tags allocated -> full=1, alloc_gnt=0; a cpl_last for tag 5 in the same cycle as alloc_req -> tag 5 granted the following cycle.
REQ-044 SHALL cover: completion arriving on the exact expiry cycle -> no timeout; rst pulse with 10 tags outstanding -> count 0 and no pulses.
